// File: rtl/sobel_frame_pingpong_packer.sv
// sobel_frame_pingpong_packer: packs Sobel pixels into bytes and stores whole frames in two alternating RAM banks.
// The optional saturating dropped-frame counter is built when SOBEL_CAP_DROP_CNT_EN is defined.
module sobel_frame_pingpong_packer #(
    parameter int WIDTH      = 640,
    parameter int HEIGHT     = 480,
    parameter int BPP        = 1,
    parameter int ADDR_WIDTH = 16
) (
    input  logic                  clk_vga,
    input  logic                  rst_n,
    input  logic                  sobel_stream_valid,
    input  logic [7:0]            sobel_stream_pixel,
    input  logic                  sobel_frame_start,
    input  logic                  frame_consume,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic [7:0]            rd_data,
    output logic                  frame_ready,
    output logic                  rd_bank,
    output logic [31:0]           frame_id,
    output logic [1:0]            banks_full,
    output logic                  capturing,
    output logic [15:0]           drop_count
);
    localparam int PAYLOAD_LEN = WIDTH * HEIGHT * BPP / 8;
    localparam int PPB = 8 / BPP;
    localparam int MW = $clog2(2 * PAYLOAD_LEN);
    localparam logic [7:0] PIX_MASK = 8'((1 << BPP) - 1);

    typedef enum logic {S_IDLE, S_CAPTURE} state_t;

    state_t                r_state, w_state_next;
    logic [ADDR_WIDTH-1:0] r_wr_addr, w_base_addr;
    logic [3:0]            r_pack_cnt, w_base_cnt;
    logic [7:0]            r_acc, w_base_acc, w_acc_next;
    logic                  r_wr_ptr, r_rd_ptr;
    logic [1:0]            r_count, r_full;
    logic [31:0]           r_frame_cnt;
    logic [31:0]           r_id [0:1];
    logic [7:0]            r_mem [0:2*PAYLOAD_LEN-1];
    logic                  w_room, w_restart, w_pix_en, w_we, w_done, w_consume_ok;
    logic [MW-1:0]         w_wr_phys, w_rd_phys;

    // Writer decisions: a start restarts packing from byte 0 and its own valid pixel is pixel 0
    always_comb begin
        w_consume_ok = frame_consume && (r_count != 2'd0);
        w_room       = (r_count != 2'd2) || w_consume_ok;
        w_restart    = sobel_frame_start && ((r_state == S_CAPTURE) || w_room);
        w_pix_en     = sobel_stream_valid && ((r_state == S_CAPTURE) || w_restart);
        w_base_addr  = w_restart ? '0 : r_wr_addr;
        w_base_cnt   = w_restart ? '0 : r_pack_cnt;
        w_base_acc   = w_restart ? '0 : r_acc;
        w_acc_next   = (w_base_acc << BPP) | (sobel_stream_pixel & PIX_MASK);
        w_we         = w_pix_en && (w_base_cnt == 4'(PPB - 1));
        w_done       = w_we && (w_base_addr == ADDR_WIDTH'(PAYLOAD_LEN - 1));
        w_wr_phys    = MW'(r_wr_ptr ? PAYLOAD_LEN : 0) + MW'(w_base_addr);
        w_rd_phys    = MW'(r_rd_ptr ? PAYLOAD_LEN : 0) + MW'(rd_addr);
        w_state_next = w_done ? S_IDLE : (w_restart ? S_CAPTURE : r_state);
    end

    // Writer state register
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) r_state <= S_IDLE;
        else        r_state <= w_state_next;
    end

    // Packing accumulator, pixel-in-byte counter and byte address
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_addr  <= '0;
            r_pack_cnt <= '0;
            r_acc      <= '0;
        end else if (w_pix_en) begin
            r_acc      <= w_acc_next;
            r_pack_cnt <= w_we ? 4'd0 : w_base_cnt + 4'd1;
            r_wr_addr  <= w_we ? w_base_addr + 1'b1 : w_base_addr;
        end else if (w_restart) begin
            r_acc      <= '0;
            r_pack_cnt <= '0;
            r_wr_addr  <= '0;
        end
    end

    // Bank bookkeeping: completion fills the write bank, consume releases the oldest bank
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr    <= 1'b0;
            r_rd_ptr    <= 1'b0;
            r_count     <= 2'd0;
            r_full      <= 2'b00;
            r_frame_cnt <= '0;
            r_id[0]     <= '0;
            r_id[1]     <= '0;
        end else begin
            r_count <= r_count + {1'b0, w_done} - {1'b0, w_consume_ok};
            if (w_consume_ok) begin
                r_rd_ptr         <= ~r_rd_ptr;
                r_full[r_rd_ptr] <= 1'b0;
            end
            if (w_done) begin
                r_wr_ptr         <= ~r_wr_ptr;
                r_full[r_wr_ptr] <= 1'b1;
                r_frame_cnt      <= r_frame_cnt + 32'd1;
                r_id[r_wr_ptr]   <= r_frame_cnt + 32'd1;
            end
        end
    end

    // Frame storage write port, left without reset so it maps onto block RAM
    always_ff @(posedge clk_vga) begin
        if (w_we) r_mem[w_wr_phys] <= w_acc_next;
    end

    // Registered read port; addresses past the payload read as zero
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n) rd_data <= 8'h00;
        else        rd_data <= ({1'b0, rd_addr} < (ADDR_WIDTH+1)'(PAYLOAD_LEN)) ? r_mem[w_rd_phys] : 8'h00;
    end

`ifdef SOBEL_CAP_DROP_CNT_EN
    logic        w_drop;
    logic [15:0] r_drop;
    assign w_drop = sobel_frame_start && ((r_state == S_CAPTURE) || !w_room);

    // Saturating count of refused starts and abandoned partial frames
    always_ff @(posedge clk_vga or negedge rst_n) begin
        if (!rst_n)                              r_drop <= '0;
        else if (w_drop && r_drop != 16'hFFFF) r_drop <= r_drop + 16'd1;
    end
    assign drop_count = r_drop;
`else
    assign drop_count = 16'h0000;
`endif

    assign frame_ready = |r_full;
    assign banks_full  = r_full;
    assign rd_bank     = r_rd_ptr;
    assign frame_id    = r_id[r_rd_ptr];
    assign capturing   = (r_state == S_CAPTURE);
endmodule

// File: tb/tb_sobel_frame_pingpong_packer.sv
// tb_sobel_frame_pingpong_packer: directed checks of capture, packing, banking, drops and reads.
module tb_sobel_frame_pingpong_packer;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        a_valid = 1'b0, a_start = 1'b0, a_consume = 1'b0;
    logic [7:0]  a_pix = 8'h00;
    logic [15:0] a_rd_addr = '0;
    logic [7:0]  a_rd_data;
    logic        a_ready, a_rd_bank, a_cap;
    logic [31:0] a_id;
    logic [1:0]  a_full;
    logic [15:0] a_drop;
    logic        b_valid = 1'b0, b_start = 1'b0, b_consume = 1'b0;
    logic [7:0]  b_pix = 8'h00;
    logic [15:0] b_rd_addr = '0;
    logic [7:0]  b_rd_data;
    logic        b_ready, b_rd_bank, b_cap;
    logic [31:0] b_id;
    logic [1:0]  b_full;
    logic [15:0] b_drop;
    int checks = 0;
    int errors = 0;
`ifdef SOBEL_CAP_DROP_CNT_EN
    localparam logic [15:0] DROP1 = 16'd1;
`else
    localparam logic [15:0] DROP1 = 16'd0;
`endif

    always #5 clk = ~clk;

    sobel_frame_pingpong_packer #(.WIDTH(8), .HEIGHT(2), .BPP(2), .ADDR_WIDTH(16)) dut_a (
        .clk_vga(clk), .rst_n(rst_n), .sobel_stream_valid(a_valid), .sobel_stream_pixel(a_pix),
        .sobel_frame_start(a_start), .frame_consume(a_consume), .rd_addr(a_rd_addr), .rd_data(a_rd_data),
        .frame_ready(a_ready), .rd_bank(a_rd_bank), .frame_id(a_id), .banks_full(a_full),
        .capturing(a_cap), .drop_count(a_drop));

    sobel_frame_pingpong_packer #(.WIDTH(8), .HEIGHT(2), .BPP(1), .ADDR_WIDTH(16)) dut_b (
        .clk_vga(clk), .rst_n(rst_n), .sobel_stream_valid(b_valid), .sobel_stream_pixel(b_pix),
        .sobel_frame_start(b_start), .frame_consume(b_consume), .rd_addr(b_rd_addr), .rd_data(b_rd_data),
        .frame_ready(b_ready), .rd_bank(b_rd_bank), .frame_id(b_id), .banks_full(b_full),
        .capturing(b_cap), .drop_count(b_drop));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        tick();
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic send_a(input int n, input int off, input bit with_start, input bit consume_last);
        for (int i = 0; i < n; i++) begin
            a_valid   = 1'b1;
            a_start   = with_start && (i == 0);
            a_pix     = 8'hA8 | 8'((i + off) % 4);
            a_consume = consume_last && (i == n - 1);
            tick();
        end
        a_valid = 1'b0;
        a_start = 1'b0;
        a_consume = 1'b0;
    endtask

    task automatic consume_a();
        a_consume = 1'b1;
        tick();
        a_consume = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        checks++; if (a_rd_data !== 8'h00) begin errors++; $display("FAIL reset_rd_data: got %h expected 00", a_rd_data); end
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL reset_frame_ready: got %b expected 0", a_ready); end
        checks++; if (a_rd_bank !== 1'b0) begin errors++; $display("FAIL reset_rd_bank: got %b expected 0", a_rd_bank); end
        checks++; if (a_id !== 32'd0) begin errors++; $display("FAIL reset_frame_id: got %0d expected 0", a_id); end
        checks++; if (a_full !== 2'b00) begin errors++; $display("FAIL reset_banks_full: got %b expected 00", a_full); end
        checks++; if (a_cap !== 1'b0) begin errors++; $display("FAIL reset_capturing: got %b expected 0", a_cap); end
        checks++; if (a_drop !== 16'd0) begin errors++; $display("FAIL reset_drop_count: got %0d expected 0", a_drop); end
        tick();
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_single_frame();
        do_reset();
        send_a(1, 0, 1'b1, 1'b0);
        checks++; if (a_cap !== 1'b1) begin errors++; $display("FAIL single_capturing_rise: got %b expected 1", a_cap); end
        send_a(14, 1, 1'b0, 1'b0);
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL single_ready_early: got %b expected 0", a_ready); end
        send_a(1, 15, 1'b0, 1'b0);
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL single_ready: got %b expected 1", a_ready); end
        checks++; if (a_full !== 2'b01) begin errors++; $display("FAIL single_banks_full: got %b expected 01", a_full); end
        checks++; if (a_id !== 32'd1) begin errors++; $display("FAIL single_frame_id: got %0d expected 1", a_id); end
        checks++; if (a_cap !== 1'b0) begin errors++; $display("FAIL single_capturing_fall: got %b expected 0", a_cap); end
        for (int a = 0; a < 5; a++) begin
            a_rd_addr = 16'(a);
            tick();
            checks++;
            if (a_rd_data !== ((a < 4) ? 8'h1B : 8'h00)) begin
                errors++;
                $display("FAIL single_read addr %0d: got %h expected %h", a, a_rd_data, (a < 4) ? 8'h1B : 8'h00);
            end
        end
        a_rd_addr = '0;
    endtask

    task automatic test_three_frames();
        do_reset();
        send_a(16, 0, 1'b1, 1'b0);
        send_a(16, 1, 1'b1, 1'b0);
        send_a(16, 2, 1'b1, 1'b0);
        checks++; if (a_full !== 2'b11) begin errors++; $display("FAIL three_banks_full: got %b expected 11", a_full); end
        checks++; if (a_id !== 32'd1) begin errors++; $display("FAIL three_frame_id: got %0d expected 1", a_id); end
        checks++; if (a_cap !== 1'b0) begin errors++; $display("FAIL three_capturing: got %b expected 0", a_cap); end
        checks++; if (a_drop !== DROP1) begin errors++; $display("FAIL three_drop_count: got %0d expected %0d", a_drop, DROP1); end
        consume_a();
        checks++; if (a_rd_bank !== 1'b1) begin errors++; $display("FAIL three_rd_bank: got %b expected 1", a_rd_bank); end
        checks++; if (a_id !== 32'd2) begin errors++; $display("FAIL three_consumed_id: got %0d expected 2", a_id); end
        checks++; if (a_full !== 2'b10) begin errors++; $display("FAIL three_consumed_full: got %b expected 10", a_full); end
        a_rd_addr = 16'd0;
        tick();
        checks++; if (a_rd_data !== 8'h6C) begin errors++; $display("FAIL three_bank1_data: got %h expected 6c", a_rd_data); end
    endtask

    task automatic test_same_cycle();
        do_reset();
        send_a(16, 0, 1'b1, 1'b0);
        send_a(16, 1, 1'b1, 1'b1);
        checks++; if (a_ready !== 1'b1) begin errors++; $display("FAIL same_ready: got %b expected 1", a_ready); end
        checks++; if (a_full !== 2'b10) begin errors++; $display("FAIL same_banks_full: got %b expected 10", a_full); end
        checks++; if (a_rd_bank !== 1'b1) begin errors++; $display("FAIL same_rd_bank: got %b expected 1", a_rd_bank); end
        checks++; if (a_id !== 32'd2) begin errors++; $display("FAIL same_frame_id: got %0d expected 2", a_id); end
        consume_a();
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL same_drain_ready: got %b expected 0", a_ready); end
        checks++; if (a_full !== 2'b00) begin errors++; $display("FAIL same_drain_full: got %b expected 00", a_full); end
    endtask

    task automatic test_reset_mid_capture();
        do_reset();
        a_rd_addr = 16'd0;
        send_a(16, 0, 1'b1, 1'b0);
        send_a(6, 0, 1'b1, 1'b0);
        checks++; if (a_cap !== 1'b1) begin errors++; $display("FAIL mid_capturing: got %b expected 1", a_cap); end
        checks++; if (a_rd_data !== 8'h1B) begin errors++; $display("FAIL mid_rd_data_before: got %h expected 1b", a_rd_data); end
        rst_n = 1'b0;
        #1;
        checks++; if (a_cap !== 1'b0) begin errors++; $display("FAIL mid_reset_capturing: got %b expected 0", a_cap); end
        checks++; if (a_full !== 2'b00) begin errors++; $display("FAIL mid_reset_full: got %b expected 00", a_full); end
        checks++; if (a_id !== 32'd0) begin errors++; $display("FAIL mid_reset_id: got %0d expected 0", a_id); end
        checks++; if (a_rd_data !== 8'h00) begin errors++; $display("FAIL mid_reset_rd_data: got %h expected 00", a_rd_data); end
        tick();
        rst_n = 1'b1;
        tick();
        send_a(16, 1, 1'b1, 1'b0);
        checks++; if (a_id !== 32'd1) begin errors++; $display("FAIL mid_next_id: got %0d expected 1", a_id); end
        checks++; if (a_rd_bank !== 1'b0) begin errors++; $display("FAIL mid_next_bank: got %b expected 0", a_rd_bank); end
        checks++; if (a_full !== 2'b01) begin errors++; $display("FAIL mid_next_full: got %b expected 01", a_full); end
        tick();
        checks++; if (a_rd_data !== 8'h6C) begin errors++; $display("FAIL mid_next_data: got %h expected 6c", a_rd_data); end
    endtask

    task automatic test_consume_empty();
        do_reset();
        consume_a();
        checks++; if (a_ready !== 1'b0) begin errors++; $display("FAIL empty_ready: got %b expected 0", a_ready); end
        checks++; if (a_rd_bank !== 1'b0) begin errors++; $display("FAIL empty_rd_bank: got %b expected 0", a_rd_bank); end
        checks++; if (a_full !== 2'b00) begin errors++; $display("FAIL empty_full: got %b expected 00", a_full); end
        send_a(16, 0, 1'b1, 1'b0);
        checks++; if (a_rd_bank !== 1'b0) begin errors++; $display("FAIL empty_next_bank: got %b expected 0", a_rd_bank); end
        checks++; if (a_full !== 2'b01) begin errors++; $display("FAIL empty_next_full: got %b expected 01", a_full); end
        checks++; if (a_id !== 32'd1) begin errors++; $display("FAIL empty_next_id: got %0d expected 1", a_id); end
    endtask

    task automatic test_bpp1_restart();
        logic [7:0] pat;
        pat = 8'b1000_0001;
        do_reset();
        for (int i = 0; i < 5; i++) begin
            b_valid = 1'b1;
            b_start = (i == 0);
            b_pix   = 8'hFF;
            tick();
        end
        checks++; if (b_cap !== 1'b1) begin errors++; $display("FAIL bpp1_capturing: got %b expected 1", b_cap); end
        for (int i = 0; i < 16; i++) begin
            b_valid = 1'b1;
            b_start = (i == 0);
            b_pix   = {7'h55, pat[7 - (i % 8)]};
            tick();
        end
        b_valid = 1'b0;
        b_start = 1'b0;
        checks++; if (b_full !== 2'b01) begin errors++; $display("FAIL bpp1_full: got %b expected 01", b_full); end
        checks++; if (b_id !== 32'd1) begin errors++; $display("FAIL bpp1_id: got %0d expected 1", b_id); end
        checks++; if (b_drop !== DROP1) begin errors++; $display("FAIL bpp1_drop_count: got %0d expected %0d", b_drop, DROP1); end
        for (int a = 0; a < 3; a++) begin
            b_rd_addr = 16'(a);
            tick();
            checks++;
            if (b_rd_data !== ((a < 2) ? 8'h81 : 8'h00)) begin
                errors++;
                $display("FAIL bpp1_read addr %0d: got %h expected %h", a, b_rd_data, (a < 2) ? 8'h81 : 8'h00);
            end
        end
    endtask

    initial begin
        test_reset();
        test_single_frame();
        test_three_frames();
        test_same_cycle();
        test_reset_mid_capture();
        test_consume_empty();
        test_bpp1_restart();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
